// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared constants and types for the time-multiplexed run-of-ones detector.
//   N_CH_DEF    : default number of requesting channels
//   RUN_LEN_DEF : default count of consecutive 1s that makes a detection
//   CW_DEF      : default width of a per-channel run counter
//   STAT_W      : width of the optional per-channel hit counters
//   ch_w()      : width of a channel index for a given channel count
//   cnt_t       : one saved run-length context entry (default width)
// -----------------------------------------------------------------------------
package seq_detect_pkg;

   localparam int N_CH_DEF    = 4;
   localparam int RUN_LEN_DEF = 3;
   localparam int CW_DEF      = 4;
   localparam int STAT_W      = 16;

   typedef logic [CW_DEF-1:0] cnt_t;

   // A single channel still needs a one-bit index so port widths stay legal.
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Round-robin arbiter. The search for a requester starts at the pointer and
// wraps from N_CH-1 to 0; after a transfer the pointer moves just past the
// winner, so every requester is served within N_CH cycles under full load.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (pointer -> 0)
//   req_i       : per-channel request
//   adv_i       : a transfer happened this cycle; advance the pointer
//   gnt_o       : one-hot grant (all zero when nothing requests)
//   gnt_idx_o   : index of the granted channel (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arb
   import seq_detect_pkg::*;
#(
   parameter int N_CH = N_CH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          req_i,
   input  logic                     adv_i,
   output logic [N_CH-1:0]          gnt_o,
   output logic [ch_w(N_CH)-1:0]    gnt_idx_o
);

   localparam int CHW = ch_w(N_CH);

   logic [CHW-1:0] ptr_q, ptr_d;
   logic [CHW-1:0] idx;
   logic           found;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = CHW'((int'(ptr_q) + k) % N_CH);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (adv_i) begin
         ptr_d = (gnt_idx_o == CHW'(N_CH - 1)) ? '0 : gnt_idx_o + CHW'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/seq_detect_sched.sv
// -----------------------------------------------------------------------------
// seq_detect_sched
// One run-of-ones detector shared by N_CH serial channels. Each cycle the
// round-robin arbiter grants one requesting channel; its saved run count is
// read, updated with the new bit (saturating at RUN_LEN, zeroed on a 0) and
// written back, and a registered detect result tagged with the channel id
// appears on the following cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid_i  : per-channel request, held until granted
//   req_bit_i    : per-channel serial data bit, sampled with req_valid_i
//   req_ready_o  : one-hot grant; transfer when req_valid_i[i] & req_ready_o[i]
//   det_valid_o  : result strobe, one cycle after the transfer
//   det_ch_o     : channel id of the result (holds when idle)
//   det_hit_o    : run count reached RUN_LEN after the update (holds when idle)
//   ctx_clr_i    : per-channel synchronous context clear, wins over an update
// Optional build macro SEQ_DETECT_SCHED_STATS_EN adds per-channel saturating
// 16-bit hit counters, readable through:
//   stat_sel_i   : channel whose counter is read
//   stat_cnt_o   : registered counter value, one cycle after stat_sel_i
// -----------------------------------------------------------------------------
module seq_detect_sched
   import seq_detect_pkg::*;
#(
   parameter int N_CH    = N_CH_DEF,
   parameter int RUN_LEN = RUN_LEN_DEF,
   parameter int CW      = CW_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          req_valid_i,
   input  logic [N_CH-1:0]          req_bit_i,
   output logic [N_CH-1:0]          req_ready_o,
   output logic                     det_valid_o,
   output logic [ch_w(N_CH)-1:0]    det_ch_o,
   output logic                     det_hit_o,
   input  logic [N_CH-1:0]          ctx_clr_i
`ifdef SEQ_DETECT_SCHED_STATS_EN
   ,
   input  logic [ch_w(N_CH)-1:0]    stat_sel_i,
   output logic [STAT_W-1:0]        stat_cnt_o
`endif
);

   localparam int             CHW     = ch_w(N_CH);
   localparam logic [CW-1:0]  RUN_MAX = CW'(RUN_LEN);

   logic [N_CH-1:0] gnt;
   logic [CHW-1:0]  g_idx;
   logic            xfer;
   logic [CW-1:0]   cnt_q [N_CH];
   logic [CW-1:0]   cur_cnt, upd_cnt;
   logic            hit_d;
   logic            det_valid_q, det_hit_q;
   logic [CHW-1:0]  det_ch_q;

   rr_arb #(.N_CH(N_CH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_valid_i),
      .adv_i     (xfer),
      .gnt_o     (gnt),
      .gnt_idx_o (g_idx)
   );

   // No grant is offered while reset is held, so nothing can transfer then.
   assign req_ready_o = rst ? '0 : gnt;
   assign xfer        = |(req_valid_i & req_ready_o);

   // Read-modify-write of the granted channel's context.
   assign cur_cnt = cnt_q[g_idx];
   assign upd_cnt = !req_bit_i[g_idx]  ? '0 :
                    (cur_cnt >= RUN_MAX) ? RUN_MAX : cur_cnt + CW'(1);
   assign hit_d   = (upd_cnt == RUN_MAX);

   // NOTE: the context array is reset explicitly because a mid-stream reset
   // must discard every channel's run history, not just the control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
         det_hit_q   <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (ctx_clr_i[i])                     cnt_q[i] <= '0;
            else if (xfer && g_idx == CHW'(i))    cnt_q[i] <= upd_cnt;
         end
         det_valid_q <= xfer;
         // The reported hit comes from the update, even if a clear wipes it.
         if (xfer) begin
            det_ch_q  <= g_idx;
            det_hit_q <= hit_d;
         end
      end
   end

   assign det_valid_o = det_valid_q;
   assign det_ch_o    = det_ch_q;
   assign det_hit_o   = det_hit_q;

`ifdef SEQ_DETECT_SCHED_STATS_EN
   logic [STAT_W-1:0] stat_q [N_CH];
   logic [STAT_W-1:0] stat_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) stat_q[i] <= '0;
         stat_cnt_q <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (ctx_clr_i[i])
               stat_q[i] <= '0;
            else if (xfer && hit_d && g_idx == CHW'(i) && stat_q[i] != '1)
               stat_q[i] <= stat_q[i] + STAT_W'(1);
         end
         stat_cnt_q <= stat_q[stat_sel_i];
      end
   end

   assign stat_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_sched
// Self-checking bench for seq_detect_sched (N_CH=4, RUN_LEN=3, CW=4).
// Each driven transfer pushes its expected {channel, hit} onto a scoreboard
// queue; the entry is popped and compared when the registered result appears.
// Stats checks are compiled only with SEQ_DETECT_SCHED_STATS_EN.
// -----------------------------------------------------------------------------
module tb_seq_detect_sched;
   import seq_detect_pkg::*;

   localparam int N  = 4;
   localparam int RL = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_valid, req_bit, ctx_clr;
   logic [N-1:0] req_ready;
   logic         det_valid;
   logic [1:0]   det_ch;
   logic         det_hit;
`ifdef SEQ_DETECT_SCHED_STATS_EN
   logic [1:0]   stat_sel;
   logic [15:0]  stat_cnt;
`endif

   always #5 clk = ~clk;

   seq_detect_sched #(.N_CH(N), .RUN_LEN(RL), .CW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_bit_i   (req_bit),
      .req_ready_o (req_ready),
      .det_valid_o (det_valid),
      .det_ch_o    (det_ch),
      .det_hit_o   (det_hit),
      .ctx_clr_i   (ctx_clr)
`ifdef SEQ_DETECT_SCHED_STATS_EN
      ,
      .stat_sel_i  (stat_sel),
      .stat_cnt_o  (stat_cnt)
`endif
   );

   typedef struct {
      int ch;
      bit hit;
   } exp_t;

   exp_t sb[$];
   int   m_cnt  [N];
   int   m_stat [N];
   int   m_ptr;
   int   total = 0;
   int   bad   = 0;
   int   last_ch;
   bit   last_hit;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i]  = 0;
         m_stat[i] = 0;
      end
      m_ptr = 0;
      sb.delete();
   endtask

   // One clock of traffic with the inputs already applied: grant checked at
   // the falling edge, the result checked 1 time unit after the rising edge.
   task automatic step();
      int           g;
      exp_t         e;
      logic [N-1:0] eg;
      @(negedge clk);
      g  = -1;
      eg = '0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr + k) % N;
         if (g < 0 && req_valid[idx]) g = idx;
      end
      if (g >= 0) eg[g] = 1'b1;
      total++;
      if (req_ready !== eg) begin
         bad++;
         $display("FAIL grant: req_ready=%b expected=%b", req_ready, eg);
      end
      if (g >= 0) begin
         int nc;
         nc       = req_bit[g] ? ((m_cnt[g] + 1 > RL) ? RL : m_cnt[g] + 1) : 0;
         m_cnt[g] = nc;
         m_ptr    = (g + 1) % N;
         e.ch     = g;
         e.hit    = (nc == RL);
         if (e.hit && m_stat[g] < 65535) m_stat[g]++;
         sb.push_back(e);
      end
      for (int i = 0; i < N; i++) begin
         if (ctx_clr[i]) begin
            m_cnt[i]  = 0;
            m_stat[i] = 0;
         end
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (det_valid !== 1'b1 || det_ch !== 2'(e.ch) || det_hit !== e.hit) begin
            bad++;
            $display("FAIL result: valid=%b ch=%0d hit=%b expected valid=1 ch=%0d hit=%b",
                     det_valid, det_ch, det_hit, e.ch, e.hit);
         end
         last_ch  = int'(det_ch);
         last_hit = det_hit;
      end else begin
         total++;
         if (det_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_valid: det_valid=%b expected 0", det_valid);
         end
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_bit   = '0;
      ctx_clr   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_bit   = '0;
      ctx_clr   = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (det_valid !== 1'b0 || det_ch !== 2'd0 || det_hit !== 1'b0 || req_ready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b ch=%0d hit=%b ready=%b expected all 0",
                  det_valid, det_ch, det_hit, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      // Pointer starts at 0: with channels 1 and 3 requesting, 1 wins.
      req_valid = 4'b1010;
      req_bit   = 4'b0000;
      step();
      total++;
      if (last_ch !== 1) begin
         bad++;
         $display("FAIL reset_ptr: first grant ch=%0d expected 1", last_ch);
      end
   endtask

   task automatic test_single();
      bit bits [6] = '{1, 1, 1, 1, 0, 1};
      bit hits [6] = '{0, 0, 1, 1, 0, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req_valid = 4'b0001;
         req_bit   = {3'b000, bits[i]};
         step();
         total++;
         if (last_ch !== 0 || last_hit !== hits[i]) begin
            bad++;
            $display("FAIL single_%0d: ch=%0d hit=%b expected ch=0 hit=%b",
                     i, last_ch, last_hit, hits[i]);
         end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_rotate();
      do_reset();
      req_valid = 4'b1111;
      req_bit   = 4'b0100;
      for (int t = 0; t < 12; t++) begin
         step();
         total++;
         // Channel 2 is granted on transfers 2, 6 and 10; the third one hits.
         if (last_ch !== t % 4 || last_hit !== (t == 10)) begin
            bad++;
            $display("FAIL rotate_%0d: ch=%0d hit=%b expected ch=%0d hit=%b",
                     t, last_ch, last_hit, t % 4, (t == 10));
         end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_interleave();
      int chs  [5] = '{1, 3, 1, 3, 1};
      bit hits [5] = '{0, 0, 0, 0, 1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req_valid         = '0;
         req_valid[chs[i]] = 1'b1;
         req_bit           = (chs[i] == 1) ? 4'b0010 : 4'b0000;
         step();
         total++;
         if (last_ch !== chs[i] || last_hit !== hits[i]) begin
            bad++;
            $display("FAIL interleave_%0d: ch=%0d hit=%b expected ch=%0d hit=%b",
                     i, last_ch, last_hit, chs[i], hits[i]);
         end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_clr();
      bit hits [6] = '{0, 0, 1, 0, 0, 1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req_valid = 4'b0010;
         req_bit   = 4'b0010;
         ctx_clr   = (i == 2) ? 4'b0010 : 4'b0000;
         step();
         total++;
         if (last_ch !== 1 || last_hit !== hits[i]) begin
            bad++;
            $display("FAIL clr_%0d: ch=%0d hit=%b expected ch=1 hit=%b",
                     i, last_ch, last_hit, hits[i]);
         end
      end
      ctx_clr   = '0;
      req_valid = '0;
      step();
      total++;
      if (det_ch !== 2'd1 || det_hit !== 1'b1) begin
         bad++;
         $display("FAIL idle_hold: ch=%0d hit=%b expected ch=1 hit=1", det_ch, det_hit);
      end
   endtask

   task automatic test_rst_mid();
      bit hits [3] = '{0, 0, 1};
      do_reset();
      req_valid = 4'b0100;
      req_bit   = 4'b0100;
      step();
      step();
      // Third 1 on ch2 transfers; reset lands just after the result registers.
      @(negedge clk);
      @(posedge clk);
      #1;
      total++;
      if (det_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_inflight: det_valid=%b expected 1", det_valid);
      end
      rst       = 1'b1;
      req_valid = '0;
      #1;
      total++;
      if (det_valid !== 1'b0 || det_ch !== 2'd0 || det_hit !== 1'b0) begin
         bad++;
         $display("FAIL rst_async: valid=%b ch=%0d hit=%b expected all 0",
                  det_valid, det_ch, det_hit);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 4'b0110;
      req_bit   = 4'b0100;
      step();
      total++;
      if (last_ch !== 1) begin
         bad++;
         $display("FAIL rst_first_grant: ch=%0d expected 1", last_ch);
      end
      for (int i = 0; i < 3; i++) begin
         req_valid = 4'b0100;
         step();
         total++;
         if (last_ch !== 2 || last_hit !== hits[i]) begin
            bad++;
            $display("FAIL rst_rerun_%0d: ch=%0d hit=%b expected ch=2 hit=%b",
                     i, last_ch, last_hit, hits[i]);
         end
      end
      req_valid = '0;
      step();
   endtask

`ifdef SEQ_DETECT_SCHED_STATS_EN
   task automatic test_stats();
      do_reset();
      stat_sel = 2'd0;
      for (int i = 0; i < 7; i++) begin
         req_valid = 4'b0001;
         req_bit   = 4'b0001;
         step();
      end
      req_valid = '0;
      step();
      total++;
      if (stat_cnt !== 16'd5 || int'(stat_cnt) !== m_stat[0]) begin
         bad++;
         $display("FAIL stats_count: stat_cnt=%0d expected 5", stat_cnt);
      end
      ctx_clr = 4'b0001;
      step();
      ctx_clr = '0;
      step();
      total++;
      if (stat_cnt !== 16'd0) begin
         bad++;
         $display("FAIL stats_clr: stat_cnt=%0d expected 0", stat_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_bit   = '0;
      ctx_clr   = '0;
`ifdef SEQ_DETECT_SCHED_STATS_EN
      stat_sel  = '0;
`endif
      last_ch   = 0;
      last_hit  = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_rotate();
      test_interleave();
      test_clr();
      test_rst_mid();
`ifdef SEQ_DETECT_SCHED_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Shares one run-of-ones detector datapath among N serial input channels.
- Each channel holds a request (bit + valid). A round-robin scheduler grants one channel per cycle.
- For the granted channel, the block reads its saved run-length context, updates it with the new bit, writes it back, and reports a registered detect flag tagged with the channel id.
- Sits between the serial front-ends and the event-logging logic. Replaces N separate consecutive-ones FSMs.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- RUN_LEN, 3, consecutive 1s needed for detection (1..15).
- CW, 4, width of the per-channel run counter; must satisfy 2^CW-1 >= RUN_LEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  N_CH  per-channel request; bit stays asserted until granted
- req_bit  input  N_CH  per-channel serial data bit, sampled with req_valid
- req_ready  output  N_CH  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
- det_valid  output  1  result strobe, one cycle after the transfer
- det_ch  output  $clog2(N_CH)  channel id of the result
- det_hit  output  1  1 when that channel's run count >= RUN_LEN after the update
- ctx_clr  input  N_CH  synchronous per-channel context clear

Behaviour:
- Reset values:
  - All per-channel counters = 0.
  - Round-robin pointer = 0.
  - req_ready, det_valid, det_ch and det_hit all = 0.
- Grant:
  - req_ready is combinational from req_valid and the rr pointer.
  - At most one bit is set, and only when at least one req_valid bit is set.
  - Search starts at the pointer and wraps from N_CH-1 to 0.
- Pointer update: on a transfer from channel g, the pointer becomes (g+1) mod N_CH. With no transfer, the pointer holds.
- Context update for the granted channel g on a transfer:
  - bit=1: cnt[g] <= min(cnt[g]+1, RUN_LEN). Saturates at RUN_LEN and never wraps.
  - bit=0: cnt[g] <= 0.
- Result, registered on the cycle after the transfer:
  - det_valid=1 and det_ch=g.
  - det_hit=(new cnt[g] == RUN_LEN).
  - A channel at saturation that receives another 1 reports det_hit=1 again. The hit is level-per-sample, not single-shot.
- With no transfer: det_valid=0. det_ch and det_hit hold their last values.
- ctx_clr:
  - ctx_clr[i] zeroes cnt[i] on the next edge.
  - If it coincides with a transfer on channel i, the clear wins: the counter becomes 0. The result for that transfer is still computed from the pre-clear update and reported.
- Other channels' contexts never change when they are not granted.
- Reset mid-stream: all contexts are lost and the pointer returns to 0. A detect result in flight is dropped (det_valid=0).
- Throughput: one transfer per cycle. Per-channel latency from req_valid to grant is at most N_CH cycles under full load.

Optional Feature:
- Macro: SEQ_DETECT_SCHED_STATS_EN.
- When defined:
  - Adds N_CH 16-bit saturating hit counters. A counter increments on each det_hit=1 result for its channel.
  - Adds ports stat_sel (input, $clog2(N_CH)) and stat_cnt (output, 16). stat_cnt is the registered value of counter[stat_sel], with one-cycle latency.
  - Counters reset to 0 on rst and on ctx_clr for their channel. A counter saturates at 16'hFFFF.
- When undefined: no stats ports or logic exist, and behaviour is otherwise identical.

Decomposition:
- Package seq_detect_pkg holds:
  - Default N_CH, RUN_LEN and CW constants.
  - Channel-id width function.
  - Stats counter width constant (16).
  - Typedef for a context entry (cnt_t).
- Sub-module rr_arb (N_CH-wide round-robin arbiter: req, advance, one-hot grant, pointer) is instantiated once. The context array and update logic stay in the top.

Test Plan:
- Single channel 0 sends 1,1,1,1,0,1 with N_CH=4, RUN_LEN=3:
  - det_hit sequence is 0,0,1,1,0,0.
  - det_ch=0 throughout, and each result arrives 1 cycle after its transfer.
- All four channels hold req_valid continuously:
  - Grants rotate 0,1,2,3,0,...
  - Channel 2 fed all 1s hits on its 3rd grant (cycle 11 after reset release). Channels fed 0s never hit.
- Interleaving isolation: ch1 sends 1,1 while ch3 sends 0,0 between them; then ch1 sends 1 -> det_hit=1 for ch1, proving the context was preserved.
- ctx_clr[1] asserted together with ch1's 3rd consecutive 1:
  - That result reports det_hit=1.
  - The next ch1 bits 1,1 report 0,0 and a third 1 reports 1.
- Async rst pulsed mid-stream (ch2 cnt=2, a result in flight):
  - Outputs go to 0 immediately.
  - After release, ch2 needs three new 1s to hit, and the first grant goes to the lowest requesting channel from 0.
- With SEQ_DETECT_SCHED_STATS_EN: 5 hits on ch0, then stat_sel=0 -> stat_cnt=5 one cycle later. After ctx_clr[0] -> stat_cnt=0.
